tlul_txn_tracker: RTL and testbench
===================================

# tlul_txn_tracker

Parametrised TileLink-UL transaction tracker and protocol checker for one A/D channel pair, typically bound passively to a master-side or slave-side link of the interconnect. It tracks outstanding requests per source ID, matches each D response to its A request, and measures latency. It flags handshake-stability, opcode, ID and timeout violations as registered, synthesizable outputs. It never drives the bus.

## Interface
Parameters:
- DATA_WIDTH, 32, A/D data width
- ADDR_WIDTH, 32, A address width
- MASK_WIDTH, DATA_WIDTH/8, A mask width
- SIZE_WIDTH, 3, size field width
- SRC_WIDTH, 2, source ID width; table depth NSRC = 2**SRC_WIDTH
- OPCODE_WIDTH, 3, opcode width
- PARAM_WIDTH, 3, param width
- TIMEOUT_CYCLES, 256, maximum A-to-D latency before a timeout error; must be at least 1
- CNT_WIDTH, 16, width of the statistics counters

Ports:
- clk_24 in 1 single clock; all logic on rising edge
- reset in 1 asynchronous, active-high reset
- a_valid, a_ready in 1 each, A handshake
- a_opcode in OPCODE_WIDTH; a_param in PARAM_WIDTH; a_size in SIZE_WIDTH; a_source in SRC_WIDTH
- a_address in ADDR_WIDTH; a_mask in MASK_WIDTH; a_data in DATA_WIDTH
- d_valid, d_ready in 1 each, D handshake
- d_opcode in OPCODE_WIDTH; d_param in PARAM_WIDTH; d_size in SIZE_WIDTH; d_source in SRC_WIDTH; d_sink in 1; d_data in DATA_WIDTH; d_error in 1
- err_valid out 1, one-cycle pulse, at least one violation detected
- err_code out 4, lowest-numbered violation code this cycle
- err_source out SRC_WIDTH, source ID tied to the reported code
- err_sticky out 7, bit k-1 set once code k is ever seen; cleared only by reset
- outstanding out SRC_WIDTH+1, number of valid table entries
- req_count, rsp_count, derr_count out CNT_WIDTH each, accepted A beats, accepted D beats, D beats with d_error=1
- max_latency out CNT_WIDTH, largest A-to-D latency seen

## Operation
- Handshakes: A fires when a_valid&&a_ready; D fires when d_valid&&d_ready. All outputs are registered.
- Per-source table, NSRC entries. Each entry holds: busy, exp_data (1 for Get), size, age[CNT_WIDTH], tout_flag.
- On an A fire with a legal opcode: entry[a_source] gets busy=1, exp_data=(opcode==4), size=a_size, age=0, tout_flag=0.
- On a D fire for a busy entry: the entry is cleared. latency = age+1. max_latency = max(max_latency, latency).
- Each cycle, every busy entry increments age, saturating at all-ones.
- Violation codes:
  - 1: A stability. Previous cycle had a_valid&&!a_ready, and this cycle a_valid dropped or any of opcode/param/size/source/address/mask/data changed.
  - 2: D stability. Same rule applied to the D fields.
  - 3: A fire with an opcode not in {0 PutFull, 1 PutPartial, 4 Get}. No table update.
  - 4: A fire on a source that is already busy. Entry overwritten.
  - 5: D fire on a source that is not busy.
  - 6: D fire with a mismatch. Expected d_opcode is 1 if exp_data, else 0; d_size must equal stored size. The entry is still cleared.
  - 7: a busy entry reaches age == TIMEOUT_CYCLES-1 with tout_flag=0. Set tout_flag. Reported once per transaction.
- Several violations in one cycle: err_code is the lowest code; all corresponding err_sticky bits are set. Timeouts on several sources: err_source is the lowest source index.
- Simultaneous A and D fire on the same source: check D against the pre-update table, then apply A. A freed-then-reissued ID is legal and is not code 4.
- Counters req_count, rsp_count and derr_count wrap modulo 2**CNT_WIDTH. max_latency saturates.

## Timing
- Reset (asynchronous assert) immediately clears to 0: all outputs, table, stability snapshots.
- Violation or statistic caused by the cycle-N rising edge sampling appears on outputs after edge N, i.e. visible during cycle N+1. err_valid is high for exactly one cycle per offending cycle.
- outstanding reflects the table after edge N: +1 on A fire, -1 on D fire, unchanged if both fire.
- Latency: an A fire at edge N with D fire at edge N+k gives latency k. k=1 is the minimum.
- Reset mid-transaction: the table is dropped. A D arriving after reset release for a pre-reset ID raises code 5.

## Test plan
- Get src 1 at edge 10, AccessAckData src 1 size 2 at edge 14 -> no error; outstanding 1 then 0; req_count=rsp_count=1; max_latency=4.
- Hold a_valid with a_ready=0, change a_address 0x100->0x104 next cycle -> err_valid pulse, err_code=1, err_sticky=0x01.
- PutFull src 2, then second A src 2 before D -> code 4, err_source=2. Then AccessAckData for it -> code 6.
- D fire on idle src 3 -> code 5. A opcode 6 -> code 3, req_count increments, outstanding unchanged.
- TIMEOUT_CYCLES=8, Get src 0 and src 1 same-edge-only-possible sequentially, no D -> code 7 for src 0 then src 1, exactly one pulse each. Late D clears the entry with no further error.
- Same-cycle D for src 0 and new A src 0 -> no error, outstanding unchanged. Assert reset with 2 outstanding -> all outputs 0 immediately.

Source files
------------

// File: rtl/tlul_txn_tracker.sv
// Passive TileLink-UL A/D tracker: per-source outstanding table, latency
// statistics and registered protocol-violation reporting.
module tlul_txn_tracker #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int SIZE_WIDTH     = 3,
    parameter int SRC_WIDTH      = 2,
    parameter int OPCODE_WIDTH   = 3,
    parameter int PARAM_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    clk_24,
    input  logic                    reset,
    input  logic                    a_valid,
    input  logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    input  logic                    d_valid,
    input  logic                    d_ready,
    input  logic [OPCODE_WIDTH-1:0] d_opcode,
    input  logic [PARAM_WIDTH-1:0]  d_param,
    input  logic [SIZE_WIDTH-1:0]   d_size,
    input  logic [SRC_WIDTH-1:0]    d_source,
    input  logic                    d_sink,
    input  logic [DATA_WIDTH-1:0]   d_data,
    input  logic                    d_error,
    output logic                    err_valid,
    output logic [3:0]              err_code,
    output logic [SRC_WIDTH-1:0]    err_source,
    output logic [6:0]              err_sticky,
    output logic [SRC_WIDTH:0]      outstanding,
    output logic [CNT_WIDTH-1:0]    req_count,
    output logic [CNT_WIDTH-1:0]    rsp_count,
    output logic [CNT_WIDTH-1:0]    derr_count,
    output logic [CNT_WIDTH-1:0]    max_latency
);

    localparam int NSRC = 2 ** SRC_WIDTH;
    localparam int AW = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH
                      + ADDR_WIDTH + MASK_WIDTH + DATA_WIDTH;
    localparam int DW = OPCODE_WIDTH + PARAM_WIDTH + SIZE_WIDTH + SRC_WIDTH
                      + 1 + DATA_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] AGE_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] TOUT_AGE = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic a_fire, d_fire, a_legal;
    logic [AW-1:0] a_bus, a_snap_q;
    logic [DW-1:0] d_bus, d_snap_q;
    logic a_stall_q, d_stall_q;
    logic [SRC_WIDTH-1:0] a_src_q, d_src_q;

    assign a_fire  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;
    assign a_legal = (a_opcode == OPCODE_WIDTH'(0)) || (a_opcode == OPCODE_WIDTH'(1))
                  || (a_opcode == OPCODE_WIDTH'(4));
    assign a_bus = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data};
    assign d_bus = {d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error};

    logic [NSRC-1:0]      busy_q, busy_d, exp_q, exp_d, tout_q, tout_d, tout_hit;
    logic [SIZE_WIDTH-1:0] size_q [NSRC];
    logic [SIZE_WIDTH-1:0] size_d [NSRC];
    logic [CNT_WIDTH-1:0]  age_q  [NSRC];
    logic [CNT_WIDTH-1:0]  age_d  [NSRC];

    logic                 d_hit;
    logic [6:0]           viol;
    logic [3:0]           code;
    logic [SRC_WIDTH-1:0] src, tout_src;
    logic [CNT_WIDTH-1:0] lat, max_d;
    logic [SRC_WIDTH:0]   busy_cnt;

    always_comb begin
        busy_d   = busy_q;
        exp_d    = exp_q;
        tout_d   = tout_q;
        size_d   = size_q;
        age_d    = age_q;
        tout_hit = '0;
        tout_src = '0;
        busy_cnt = '0;
        d_hit    = busy_q[d_source];
        lat      = (age_q[d_source] == AGE_MAX) ? AGE_MAX : age_q[d_source] + 1'b1;
        max_d    = max_latency;

        for (int i = 0; i < NSRC; i++) begin
            if (busy_q[i] && age_q[i] != AGE_MAX)
                age_d[i] = age_q[i] + 1'b1;
            // A response landing on the timeout edge itself closes in time.
            if (busy_q[i] && !tout_q[i] && age_q[i] == TOUT_AGE
                && !(d_fire && d_source == SRC_WIDTH'(i))) begin
                tout_hit[i] = 1'b1;
                tout_d[i]   = 1'b1;
            end
        end
        for (int i = NSRC - 1; i >= 0; i--)
            if (tout_hit[i]) tout_src = SRC_WIDTH'(i);

        // D is checked against the pre-update table, then A is applied.
        if (d_fire && d_hit) begin
            busy_d[d_source] = 1'b0;
            exp_d[d_source]  = 1'b0;
            tout_d[d_source] = 1'b0;
            size_d[d_source] = '0;
            age_d[d_source]  = '0;
            if (lat > max_latency) max_d = lat;
        end
        if (a_fire && a_legal) begin
            busy_d[a_source] = 1'b1;
            exp_d[a_source]  = (a_opcode == OPCODE_WIDTH'(4));
            tout_d[a_source] = 1'b0;
            size_d[a_source] = a_size;
            age_d[a_source]  = '0;
        end
        for (int i = 0; i < NSRC; i++)
            busy_cnt = busy_cnt + (SRC_WIDTH + 1)'(busy_d[i]);

        viol[0] = a_stall_q && (!a_valid || a_bus != a_snap_q);
        viol[1] = d_stall_q && (!d_valid || d_bus != d_snap_q);
        viol[2] = a_fire && !a_legal;
        viol[3] = a_fire && a_legal && busy_q[a_source]
               && !(d_fire && d_source == a_source);
        viol[4] = d_fire && !d_hit;
        viol[5] = d_fire && d_hit
               && (d_opcode != OPCODE_WIDTH'(exp_q[d_source])
                   || d_size != size_q[d_source]);
        viol[6] = |tout_hit;

        code = '0;
        for (int k = 6; k >= 0; k--)
            if (viol[k]) code = 4'(k + 1);
        case (code)
            4'd1:       src = a_src_q;
            4'd2:       src = d_src_q;
            4'd3, 4'd4: src = a_source;
            4'd5, 4'd6: src = d_source;
            4'd7:       src = tout_src;
            default:    src = '0;
        endcase
    end

    always_ff @(posedge clk_24 or posedge reset) begin
        if (reset) begin
            a_stall_q   <= 1'b0;
            d_stall_q   <= 1'b0;
            a_snap_q    <= '0;
            d_snap_q    <= '0;
            a_src_q     <= '0;
            d_src_q     <= '0;
            busy_q      <= '0;
            exp_q       <= '0;
            tout_q      <= '0;
            for (int i = 0; i < NSRC; i++) begin
                size_q[i] <= '0;
                age_q[i]  <= '0;
            end
            err_valid   <= 1'b0;
            err_code    <= '0;
            err_source  <= '0;
            err_sticky  <= '0;
            outstanding <= '0;
            req_count   <= '0;
            rsp_count   <= '0;
            derr_count  <= '0;
            max_latency <= '0;
        end else begin
            a_stall_q   <= a_valid && !a_ready;
            d_stall_q   <= d_valid && !d_ready;
            a_snap_q    <= a_bus;
            d_snap_q    <= d_bus;
            a_src_q     <= a_source;
            d_src_q     <= d_source;
            busy_q      <= busy_d;
            exp_q       <= exp_d;
            tout_q      <= tout_d;
            size_q      <= size_d;
            age_q       <= age_d;
            err_valid   <= |viol;
            err_code    <= code;
            err_source  <= src;
            err_sticky  <= err_sticky | viol;
            outstanding <= busy_cnt;
            req_count   <= req_count + CNT_WIDTH'(a_fire);
            rsp_count   <= rsp_count + CNT_WIDTH'(d_fire);
            derr_count  <= derr_count + CNT_WIDTH'(d_fire && d_error);
            max_latency <= max_d;
        end
    end

endmodule

// File: tb/tb_tlul_txn_tracker.sv
// Directed bench for tlul_txn_tracker with a short timeout so the
// timeout path is reachable in a few cycles.
module tb_tlul_txn_tracker;

    localparam int SW = 2;
    localparam int CW = 16;

    logic          clk_24 = 1'b0;
    logic          reset  = 1'b0;
    logic          a_valid, a_ready, d_valid, d_ready, d_sink, d_error;
    logic [2:0]    a_opcode, a_param, a_size, d_opcode, d_param, d_size;
    logic [SW-1:0] a_source, d_source;
    logic [31:0]   a_address, a_data, d_data;
    logic [3:0]    a_mask;
    logic          err_valid;
    logic [3:0]    err_code;
    logic [SW-1:0] err_source;
    logic [6:0]    err_sticky;
    logic [SW:0]   outstanding;
    logic [CW-1:0] req_count, rsp_count, derr_count, max_latency;

    int checks = 0;
    int errors = 0;

    tlul_txn_tracker #(.TIMEOUT_CYCLES(8)) dut (
        .clk_24(clk_24), .reset(reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_param(a_param), .a_size(a_size), .a_source(a_source),
        .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_param(d_param), .d_size(d_size), .d_source(d_source),
        .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
        .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
        .err_sticky(err_sticky), .outstanding(outstanding),
        .req_count(req_count), .rsp_count(rsp_count),
        .derr_count(derr_count), .max_latency(max_latency)
    );

    always #5 clk_24 = ~clk_24;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_24);
        #1;
    endtask

    task automatic idle();
        a_valid = 1'b0; a_ready = 1'b1; d_valid = 1'b0; d_ready = 1'b1;
        d_error = 1'b0;
    endtask

    task automatic a_req(input logic [2:0] op, input logic [SW-1:0] src,
                         input logic [2:0] sz);
        a_valid = 1'b1; a_ready = 1'b1; a_opcode = op; a_source = src;
        a_size = sz;
    endtask

    task automatic d_rsp(input logic [2:0] op, input logic [SW-1:0] src,
                         input logic [2:0] sz, input logic er);
        d_valid = 1'b1; d_ready = 1'b1; d_opcode = op; d_source = src;
        d_size = sz; d_error = er;
    endtask

    task automatic chk_err(input string tag, input logic [3:0] c,
                           input logic [SW-1:0] s);
        chk({tag, "_valid"}, 32'(err_valid), 32'd1);
        chk({tag, "_code"}, 32'(err_code), 32'(c));
        chk({tag, "_src"}, 32'(err_source), 32'(s));
    endtask

    initial begin
        a_valid = 0; a_ready = 0; a_opcode = 0; a_param = 0; a_size = 0;
        a_source = 0; a_address = 32'h100; a_mask = 4'hf; a_data = 0;
        d_valid = 0; d_ready = 0; d_opcode = 0; d_param = 0; d_size = 0;
        d_source = 0; d_sink = 0; d_data = 0; d_error = 0;
        #1 reset = 1'b1;
        #1;
        chk("rst_err_valid", 32'(err_valid), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_req", 32'(req_count), 0);
        step();
        reset = 1'b0;
        idle();
        step();

        // Get src1, AccessAckData four edges later
        a_req(3'd4, 2'd1, 3'd2);
        step();
        chk("get_out1", 32'(outstanding), 1);
        chk("get_req", 32'(req_count), 1);
        idle();
        step(); step(); step();
        d_rsp(3'd1, 2'd1, 3'd2, 1'b0);
        step();
        chk("ack_noerr", 32'(err_valid), 0);
        chk("ack_out0", 32'(outstanding), 0);
        chk("ack_rsp", 32'(rsp_count), 1);
        chk("ack_lat", 32'(max_latency), 4);
        idle();

        // A stalled request changes address
        a_req(3'd4, 2'd0, 3'd0);
        a_ready = 1'b0;
        a_address = 32'h100;
        step();
        chk("stall_noerr", 32'(err_valid), 0);
        a_address = 32'h104;
        step();
        chk_err("astab", 4'd1, 2'd0);
        chk("astab_sticky", 32'(err_sticky), 32'h01);
        a_ready = 1'b1;
        step();
        chk("astab_pulse1", 32'(err_valid), 0);
        chk("astab_out", 32'(outstanding), 1);
        idle();
        d_rsp(3'd1, 2'd0, 3'd0, 1'b0);
        step();
        chk("astab_ack", 32'(err_valid), 0);
        idle();

        // PutFull src2 twice, then wrong response opcode
        a_req(3'd0, 2'd2, 3'd2);
        step();
        chk("put_out", 32'(outstanding), 1);
        step();
        chk_err("busy", 4'd4, 2'd2);
        chk("busy_out", 32'(outstanding), 1);
        idle();
        d_rsp(3'd1, 2'd2, 3'd2, 1'b0);
        step();
        chk_err("mism", 4'd6, 2'd2);
        chk("mism_out", 32'(outstanding), 0);
        chk("mism_sticky", 32'(err_sticky), 32'h29);
        chk("mism_req", 32'(req_count), 4);

        // D on idle src3, then illegal opcode
        d_rsp(3'd0, 2'd3, 3'd2, 1'b1);
        step();
        chk_err("idle_d", 4'd5, 2'd3);
        chk("derr", 32'(derr_count), 1);
        chk("idle_rsp", 32'(rsp_count), 4);
        idle();
        a_req(3'd6, 2'd1, 3'd2);
        step();
        chk_err("badop", 4'd3, 2'd1);
        chk("badop_req", 32'(req_count), 5);
        chk("badop_out", 32'(outstanding), 0);
        chk("badop_sticky", 32'(err_sticky), 32'h3d);

        // Timeout on src0 then src1
        a_req(3'd4, 2'd0, 3'd2);
        step();
        a_req(3'd4, 2'd1, 3'd2);
        step();
        chk("tout_out2", 32'(outstanding), 2);
        idle();
        for (int i = 0; i < 6; i++) step();
        chk("tout_early", 32'(err_valid), 0);
        step();
        chk_err("tout0", 4'd7, 2'd0);
        step();
        chk_err("tout1", 4'd7, 2'd1);
        step();
        chk("tout_once", 32'(err_valid), 0);
        chk("tout_sticky", 32'(err_sticky), 32'h7d);
        d_rsp(3'd1, 2'd0, 3'd2, 1'b0);
        step();
        chk("late_noerr", 32'(err_valid), 0);
        chk("late_out", 32'(outstanding), 1);
        chk("late_lat", 32'(max_latency), 11);
        idle();

        // Free and reissue src0 in one cycle
        a_req(3'd4, 2'd0, 3'd2);
        step();
        d_rsp(3'd1, 2'd0, 3'd2, 1'b0);
        step();
        chk("reuse_noerr", 32'(err_valid), 0);
        chk("reuse_out", 32'(outstanding), 2);
        chk("reuse_req", 32'(req_count), 9);
        chk("reuse_lat", 32'(max_latency), 11);
        idle();

        // Asynchronous reset with entries outstanding
        #2 reset = 1'b1;
        #1;
        chk("mrst_out", 32'(outstanding), 0);
        chk("mrst_req", 32'(req_count), 0);
        chk("mrst_rsp", 32'(rsp_count), 0);
        chk("mrst_sticky", 32'(err_sticky), 0);
        chk("mrst_lat", 32'(max_latency), 0);
        step();
        reset = 1'b0;
        d_rsp(3'd1, 2'd1, 3'd2, 1'b0);
        step();
        chk_err("post_rst", 4'd5, 2'd1);
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
